pipe_mult_tree: RTL and testbench



---
 rtl/pipe_mult_tree.sv | 100 ++++++++++
 tb/tb_pipe_mult_tree.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mult_tree.sv
// Fully pipelined WIDTH x WIDTH multiplier: registered partial products followed by a
// registered binary adder tree, with a globally stalled valid/tag chain alongside.
module pipe_mult_tree #(
    parameter int WIDTH = 24,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    input  logic [TAG_W-1:0]   tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int PW     = 2 * WIDTH;

    logic                        adv;
    logic                        accept;
    logic [PW-1:0]               a_ext;
    logic [PW-1:0]               pp   [WIDTH];
    logic [PW-1:0]               node [LEVELS+1][WIDTH];
    logic [LEVELS:0]             vld;
    logic [(LEVELS+1)*TAG_W-1:0] tg;

    assign adv      = !vld[LEVELS] || out_ready;
    assign in_ready = adv && !flush && !rst;
    assign accept   = in_valid && in_ready;
    assign a_ext    = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        if (i == WIDTH - 1) begin : g_msb
            // In signed mode b's MSB weighs -2^(WIDTH-1), so its row is subtracted
            assign pp[i] = !b[i] ? '0 : (sgn ? -(a_ext << i) : (a_ext << i));
        end else begin : g_row
            assign pp[i] = b[i] ? (a_ext << i) : '0;
        end
    end

    for (genvar j = 0; j < WIDTH; j++) begin : g_s1
        always_ff @(posedge clk) begin
            if (rst) begin
                node[0][j] <= '0;
            end else if (adv) begin
                node[0][j] <= pp[j];
            end
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int N_PREV = (WIDTH + (1 << (l - 1)) - 1) >> (l - 1);
        localparam int N_CUR  = (N_PREV + 1) / 2;
        for (genvar j = 0; j < N_CUR; j++) begin : g_node
            if (2 * j + 1 < N_PREV) begin : g_add
                always_ff @(posedge clk) begin
                    if (rst) begin
                        node[l][j] <= '0;
                    end else if (adv) begin
                        node[l][j] <= node[l-1][2*j] + node[l-1][2*j+1];
                    end
                end
            end else begin : g_pass
                always_ff @(posedge clk) begin
                    if (rst) begin
                        node[l][j] <= '0;
                    end else if (adv) begin
                        node[l][j] <= node[l-1][2*j];
                    end
                end
            end
        end
    end

    // Flush clears valids even while stalled; data and tags only move on adv
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            tg  <= '0;
        end else begin
            if (flush) begin
                vld <= '0;
            end else if (adv) begin
                vld <= {vld[LEVELS-1:0], accept};
            end
            if (adv) begin
                tg <= {tg[LEVELS*TAG_W-1:0], tag};
            end
        end
    end

    assign out_valid = vld[LEVELS];
    assign prod      = node[LEVELS][0];
    assign out_tag   = tg[LEVELS*TAG_W +: TAG_W];
endmodule

// File: tb/tb_pipe_mult_tree.sv
// Self-checking bench for pipe_mult_tree: WIDTH=24 main instance plus WIDTH=8/2/32
// instances, checked against an arithmetic reference model and in-order scoreboards.
module tb_pipe_mult_tree;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, sgn, out_valid, out_ready;
    logic [23:0] a, b;
    logic [3:0]  tag, out_tag;
    logic [47:0] prod;

    logic        s_rst, s_flush, s_valid, s_sgn, s_ordy;
    logic [31:0] s_a, s_b;
    logic [3:0]  s_tag, t8, t2, t32;
    logic        r8, r2, r32, v8, v2, v32;
    logic [15:0] p8;
    logic [3:0]  p2;
    logic [63:0] p32;

    int n_cmp = 0;
    int n_bad = 0;

    logic [47:0] qp[$];
    logic [3:0]  qt[$];
    logic [15:0] q8p[$];
    logic [3:0]  q8t[$];
    logic [3:0]  q2p[$];
    logic [3:0]  q2t[$];
    logic [63:0] q32p[$];
    logic [3:0]  q32t[$];

    always #5 clk = ~clk;

    pipe_mult_tree #(.WIDTH(24), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sgn(sgn), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .out_tag(out_tag));

    pipe_mult_tree #(.WIDTH(8), .TAG_W(4)) u_w8 (
        .clk(clk), .rst(s_rst), .flush(s_flush), .in_valid(s_valid), .in_ready(r8),
        .a(s_a[7:0]), .b(s_b[7:0]), .sgn(s_sgn), .tag(s_tag), .out_valid(v8),
        .out_ready(s_ordy), .prod(p8), .out_tag(t8));

    pipe_mult_tree #(.WIDTH(2), .TAG_W(4)) u_w2 (
        .clk(clk), .rst(s_rst), .flush(s_flush), .in_valid(s_valid), .in_ready(r2),
        .a(s_a[1:0]), .b(s_b[1:0]), .sgn(s_sgn), .tag(s_tag), .out_valid(v2),
        .out_ready(s_ordy), .prod(p2), .out_tag(t2));

    pipe_mult_tree #(.WIDTH(32), .TAG_W(4)) u_w32 (
        .clk(clk), .rst(s_rst), .flush(s_flush), .in_valid(s_valid), .in_ready(r32),
        .a(s_a), .b(s_b), .sgn(s_sgn), .tag(s_tag), .out_valid(v32),
        .out_ready(s_ordy), .prod(p32), .out_tag(t32));

    // Exact product of w-bit operands, reduced to 2*w bits
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input int w);
        longint      sx, sy, p;
        logic [31:0] m;
        m  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        sx = longint'({32'd0, x & m});
        sy = longint'({32'd0, y & m});
        if (s) begin
            sx = (sx <<< (64 - w)) >>> (64 - w);
            sy = (sy <<< (64 - w)) >>> (64 - w);
        end
        p = sx * sy;
        if (w < 32) p = p & ((64'sd1 <<< (2 * w)) - 64'sd1);
        return 64'(p);
    endfunction

    task automatic drive(input logic v, input logic [23:0] x, input logic [23:0] y,
                         input logic s, input logic [3:0] t, input logic ordy,
                         input logic r, input logic f);
        @(negedge clk);
        in_valid = v; a = x; b = y; sgn = s; tag = t; out_ready = ordy; rst = r; flush = f;
        #1;
    endtask

    task automatic sdrive(input logic v, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [3:0] t, input logic r);
        @(negedge clk);
        s_valid = v; s_a = x; s_b = y; s_sgn = s; s_tag = t; s_rst = r; s_ordy = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 24'h123, 24'h456, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        n_cmp++; if (prod !== 48'd0) begin n_bad++; $display("FAIL rst_prod got=%h want=0", prod); end
        n_cmp++; if (out_tag !== 4'd0) begin n_bad++; $display("FAIL rst_out_tag got=%h want=0", out_tag); end
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_corners();
        logic [23:0] ta [6] = '{24'hFFFFFF, 24'd3, 24'hFFFFFF, 24'h800000, 24'h800000, 24'hFFFFFD};
        logic [23:0] tb [6] = '{24'hFFFFFF, 24'd5, 24'hFFFFFF, 24'h800000, 24'h7FFFFF, 24'd5};
        logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0]  tt [6] = '{4'd5, 4'd1, 4'd9, 4'd12, 4'd7, 4'd15};
        logic [47:0] te [6] = '{48'hFFFFFE000001, 48'd15, 48'h000000000001,
                                48'h400000000000, 48'hC00000800000, 48'hFFFFFFFFFFF1};
        int lat;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, ta[k], tb[k], ts[k], tt[k], 1'b1, 1'b0, 1'b0);
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL corner%0d_accept got=%0b want=1", k, in_ready); end
            lat = 0;
            for (int c = 1; c <= 20; c++) begin
                drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
                if (out_valid) begin lat = c; break; end
            end
            n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL corner%0d_latency got=%0d want=6", k, lat); end
            n_cmp++; if (prod !== te[k]) begin n_bad++; $display("FAIL corner%0d_prod got=%h want=%h", k, prod, te[k]); end
            n_cmp++; if (out_tag !== tt[k]) begin n_bad++; $display("FAIL corner%0d_tag got=%h want=%h", k, out_tag, tt[k]); end
        end
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_streaming();
        int sent = 0, got = 0, first_acc = -1, first_out = -1, gaps = 0;
        logic [23:0] x, y; logic s; logic [3:0] t; logic [63:0] r; logic [47:0] ep; logic [3:0] et;
        for (int c = 0; c < 200 && got < 64; c++) begin
            x = 24'($urandom); y = 24'($urandom); s = 1'($urandom); t = 4'($urandom);
            drive(sent < 64, x, y, s, t, 1'b1, 1'b0, 1'b0);
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = c;
                r = ref_mul({8'd0, x}, {8'd0, y}, s, 24);
                qp.push_back(r[47:0]); qt.push_back(t); sent++;
            end
            if (out_valid) begin
                if (first_out < 0) first_out = c;
                if (qp.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL stream_unexpected got_prod=%h want=none", prod);
                end else begin
                    ep = qp.pop_front(); et = qt.pop_front();
                    n_cmp++; if (prod !== ep) begin n_bad++; $display("FAIL stream_prod got=%h want=%h", prod, ep); end
                    n_cmp++; if (out_tag !== et) begin n_bad++; $display("FAIL stream_tag got=%h want=%h", out_tag, et); end
                end
                got++;
            end else if (first_out >= 0) begin
                gaps++;
            end
        end
        n_cmp++; if (first_out - first_acc != 6) begin n_bad++; $display("FAIL stream_latency got=%0d want=6", first_out - first_acc); end
        n_cmp++; if (got != 64) begin n_bad++; $display("FAIL stream_count got=%0d want=64", got); end
        n_cmp++; if (gaps != 0) begin n_bad++; $display("FAIL stream_gaps got=%0d want=0", gaps); end
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0;
        logic pend = 1'b0, ordy;
        logic [23:0] x = '0, y = '0; logic s = 1'b0; logic [3:0] t = '0;
        logic [63:0] r; logic [47:0] ep, hold_p = '0; logic [3:0] et, hold_t = '0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            if (!pend && sent < 10) begin
                x = 24'($urandom); y = 24'($urandom); s = 1'($urandom); t = 4'(sent); pend = 1'b1;
            end
            ordy = !(c >= 8 && c <= 10);
            drive(pend, x, y, s, t, ordy, 1'b0, 1'b0);
            if (c == 8) begin hold_p = prod; hold_t = out_tag; end
            if (c >= 8 && c <= 10) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c=%0d got=%0b want=0", c, in_ready); end
            end
            if (c >= 9 && c <= 11) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid c=%0d got=%0b want=1", c, out_valid); end
                n_cmp++; if (prod !== hold_p) begin n_bad++; $display("FAIL bp_hold_prod c=%0d got=%h want=%h", c, prod, hold_p); end
                n_cmp++; if (out_tag !== hold_t) begin n_bad++; $display("FAIL bp_hold_tag c=%0d got=%h want=%h", c, out_tag, hold_t); end
            end
            if (in_valid && in_ready) begin
                r = ref_mul({8'd0, x}, {8'd0, y}, s, 24);
                qp.push_back(r[47:0]); qt.push_back(t); sent++; pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (qp.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL bp_unexpected got_tag=%h want=none", out_tag);
                end else begin
                    ep = qp.pop_front(); et = qt.pop_front();
                    n_cmp++; if (prod !== ep) begin n_bad++; $display("FAIL bp_prod got=%h want=%h", prod, ep); end
                    n_cmp++; if (out_tag !== et) begin n_bad++; $display("FAIL bp_tag got=%h want=%h", out_tag, et); end
                end
                got++;
            end
        end
        n_cmp++; if (got != 10) begin n_bad++; $display("FAIL bp_count got=%0d want=10", got); end
    endtask

    task automatic test_random_flow();
        int sent = 0, got = 0;
        logic pend = 1'b0, was_stalled = 1'b0;
        logic [23:0] x = '0, y = '0; logic s = 1'b0; logic [3:0] t = '0;
        logic [63:0] r; logic [47:0] ep, last_p = '0; logic [3:0] et, last_t = '0;
        for (int c = 0; c < 2000 && got < 150; c++) begin
            if (!pend && sent < 150 && $urandom_range(9, 0) < 7) begin
                x = 24'($urandom); y = 24'($urandom); s = 1'($urandom); t = 4'($urandom); pend = 1'b1;
            end
            drive(pend, x, y, s, t, $urandom_range(9, 0) < 6, 1'b0, 1'b0);
            if (was_stalled) begin
                n_cmp++; if (out_valid !== 1'b1 || prod !== last_p || out_tag !== last_t) begin
                    n_bad++; $display("FAIL rnd_stall_hold got=%0b/%h/%h want=1/%h/%h", out_valid, prod, out_tag, last_p, last_t);
                end
            end
            was_stalled = out_valid && !out_ready; last_p = prod; last_t = out_tag;
            if (in_valid && in_ready) begin
                r = ref_mul({8'd0, x}, {8'd0, y}, s, 24);
                qp.push_back(r[47:0]); qt.push_back(t); sent++; pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (qp.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL rnd_unexpected got_tag=%h want=none", out_tag);
                end else begin
                    ep = qp.pop_front(); et = qt.pop_front();
                    n_cmp++; if (prod !== ep) begin n_bad++; $display("FAIL rnd_prod got=%h want=%h", prod, ep); end
                    n_cmp++; if (out_tag !== et) begin n_bad++; $display("FAIL rnd_tag got=%h want=%h", out_tag, et); end
                end
                got++;
            end
        end
        n_cmp++; if (got != 150) begin n_bad++; $display("FAIL rnd_count got=%0d want=150", got); end
    endtask

    task automatic test_reset_midflight();
        int stray = 0;
        for (int k = 0; k < 4; k++) drive(1'b1, 24'($urandom), 24'($urandom), 1'b0, 4'(k), 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%0b want=0", out_valid); end
        n_cmp++; if (prod !== 48'd0) begin n_bad++; $display("FAIL midrst_prod got=%h want=0", prod); end
        n_cmp++; if (out_tag !== 4'd0) begin n_bad++; $display("FAIL midrst_tag got=%h want=0", out_tag); end
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (out_valid) stray++;
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL midrst_stale got=%0d want=0", stray); end
    endtask

    task automatic test_flush_midflight();
        int stray = 0;
        for (int k = 0; k < 4; k++) drive(1'b1, 24'($urandom), 24'($urandom), 1'b1, 4'(k), 1'b1, 1'b0, 1'b0);
        drive(1'b1, 24'h000111, 24'h000222, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got=%0b want=0", in_ready); end
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (out_valid) stray++;
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL flush_stale got=%0d want=0", stray); end
    endtask

    task automatic test_flush_stall();
        int stray = 0;
        logic seen = 1'b0;
        drive(1'b1, 24'h00ABCD, 24'h000321, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 20 && !seen; c++) begin
            drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            seen = out_valid;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL fstall_arrive got=%0b want=1", seen); end
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL fstall_held got=%0b/%0b want=1/0", out_valid, in_ready);
        end
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
            if (out_valid) stray++;
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL fstall_dropped got=%0d want=0", stray); end
    endtask

    task automatic test_param_latency();
        int l8 = 0, l2 = 0, l32 = 0;
        logic [31:0] x = 32'hC3A5_F00F, y = 32'h8001_7FFE;
        logic [63:0] r;
        sdrive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        sdrive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        n_cmp++; if ({v8, v2, v32} !== 3'b000 || p8 !== 16'd0 || p32 !== 64'd0) begin
            n_bad++; $display("FAIL sweep_reset got=%b/%h/%h want=000/0/0", {v8, v2, v32}, p8, p32);
        end
        sdrive(1'b1, x, y, 1'b1, 4'h9, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            sdrive(1'b0, '0, '0, 1'b0, '0, 1'b0);
            if (v8 && l8 == 0) begin
                l8 = c; r = ref_mul(x, y, 1'b1, 8);
                n_cmp++; if (p8 !== r[15:0] || t8 !== 4'h9) begin n_bad++; $display("FAIL w8_single got=%h/%h want=%h/9", p8, t8, r[15:0]); end
            end
            if (v2 && l2 == 0) begin
                l2 = c; r = ref_mul(x, y, 1'b1, 2);
                n_cmp++; if (p2 !== r[3:0] || t2 !== 4'h9) begin n_bad++; $display("FAIL w2_single got=%h/%h want=%h/9", p2, t2, r[3:0]); end
            end
            if (v32 && l32 == 0) begin
                l32 = c; r = ref_mul(x, y, 1'b1, 32);
                n_cmp++; if (p32 !== r || t32 !== 4'h9) begin n_bad++; $display("FAIL w32_single got=%h/%h want=%h/9", p32, t32, r); end
            end
        end
        n_cmp++; if (l8 != 4) begin n_bad++; $display("FAIL w8_latency got=%0d want=4", l8); end
        n_cmp++; if (l2 != 2) begin n_bad++; $display("FAIL w2_latency got=%0d want=2", l2); end
        n_cmp++; if (l32 != 6) begin n_bad++; $display("FAIL w32_latency got=%0d want=6", l32); end
    endtask

    // WIDTH=8 operand space (every a and every b, a^b = 0 mod 4) in both modes;
    // the same stream drives WIDTH=2 and WIDTH=32 with random upper operand bits.
    task automatic test_param_sweep();
        logic [7:0] ia, ib; logic s, v; logic [31:0] x, y; logic [3:0] t;
        logic [63:0] r; logic [15:0] e8; logic [3:0] e2, et; logic [63:0] e32;
        for (int i = 0; i < 131072 + 10; i++) begin
            v = 1'b0; x = '0; y = '0; s = 1'b0; t = '0;
            if (i < 131072) begin
                ia = 8'(i >> 8); ib = 8'(i); s = 1'(i >> 16);
                if (((ia ^ ib) & 8'd3) != 8'd0) continue;
                x = {24'($urandom), ia}; y = {24'($urandom), ib}; t = 4'($urandom); v = 1'b1;
            end
            sdrive(v, x, y, s, t, 1'b0);
            if (s_valid && r8) begin
                r = ref_mul(x, y, s, 8);  q8p.push_back(r[15:0]); q8t.push_back(t);
                r = ref_mul(x, y, s, 2);  q2p.push_back(r[3:0]);  q2t.push_back(t);
                r = ref_mul(x, y, s, 32); q32p.push_back(r);      q32t.push_back(t);
            end
            if (v8) begin
                if (q8p.size() == 0) begin n_cmp++; n_bad++; $display("FAIL w8_unexpected got=%h want=none", p8); end
                else begin
                    e8 = q8p.pop_front(); et = q8t.pop_front();
                    n_cmp++; if (p8 !== e8 || t8 !== et) begin n_bad++; $display("FAIL w8_prod got=%h/%h want=%h/%h", p8, t8, e8, et); end
                end
            end
            if (v2) begin
                if (q2p.size() == 0) begin n_cmp++; n_bad++; $display("FAIL w2_unexpected got=%h want=none", p2); end
                else begin
                    e2 = q2p.pop_front(); et = q2t.pop_front();
                    n_cmp++; if (p2 !== e2 || t2 !== et) begin n_bad++; $display("FAIL w2_prod got=%h/%h want=%h/%h", p2, t2, e2, et); end
                end
            end
            if (v32) begin
                if (q32p.size() == 0) begin n_cmp++; n_bad++; $display("FAIL w32_unexpected got=%h want=none", p32); end
                else begin
                    e32 = q32p.pop_front(); et = q32t.pop_front();
                    n_cmp++; if (p32 !== e32 || t32 !== et) begin n_bad++; $display("FAIL w32_prod got=%h/%h want=%h/%h", p32, t32, e32, et); end
                end
            end
        end
        n_cmp++; if (q8p.size() + q2p.size() + q32p.size() != 0) begin
            n_bad++; $display("FAIL sweep_leftover got=%0d want=0", q8p.size() + q2p.size() + q32p.size());
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; tag = '0; out_ready = 1'b1;
        s_rst = 1'b1; s_flush = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_sgn = 1'b0; s_tag = '0; s_ordy = 1'b1;
        test_reset();
        test_corners();
        test_streaming();
        test_backpressure();
        test_random_flow();
        n_cmp++; if (qp.size() != 0) begin n_bad++; $display("FAIL main_leftover got=%0d want=0", qp.size()); end
        test_reset_midflight();
        test_flush_midflight();
        test_flush_stall();
        test_param_latency();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
